// File: rtl/life_step.sv
// In-place Conway B3/S23 generation engine for a WIDTH x HEIGHT single-bit cell BRAM.
// Define LIFE_TORUS_EN to wrap the grid edges; otherwise cells outside the grid are dead.
module life_step #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       gen_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_din,
  input  logic              mem_dout
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = ADDR_W - CW;
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] PEN_ROW  = RW'(HEIGHT - 2);
  localparam logic [CW:0]   RD_LAST  = (CW + 1)'(WIDTH);
  localparam logic [CW:0]   WR_LAST  = (CW + 1)'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD_TOP, LOAD_ROW0, FETCH, WRITE, FINISH} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    prev_q, cur_q, next_q;
  logic [WIDTH-1:0]    next_full_d, last_next_d;
  logic [CW:0]         cnt_q;
  logic [RW-1:0]       row_q;
  logic                busy_q, done_q, we_q, din_q;
  logic [15:0]         gen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CW-1:0]       col_lo, cap_idx;
`ifdef LIFE_TORUS_EN
  logic [WIDTH-1:0]    row0_orig_q;
  assign last_next_d = row0_orig_q;
`else
  assign last_next_d = '0;
`endif

  assign col_lo  = cnt_q[CW-1:0];
  assign cap_idx = col_lo - CW'(1);

  // The last bit of a fetched row arrives on the same edge that enters WRITE.
  always_comb begin
    next_full_d = next_q;
    next_full_d[WIDTH-1] = mem_dout;
  end

  function automatic logic [ADDR_W-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return {r, c};
  endfunction

  function automatic logic cell_next(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] c,
                                     input logic [WIDTH-1:0] n, input logic [CW-1:0] col);
    logic [CW-1:0] cl, cr;
    logic [3:0]    sum;
    logic          l_ok, r_ok;
    cl = col - CW'(1);
    cr = col + CW'(1);
`ifdef LIFE_TORUS_EN
    l_ok = 1'b1;
    r_ok = 1'b1;
`else
    l_ok = (col != '0);
    r_ok = (col != CW'(WIDTH - 1));
`endif
    sum = 4'(p[col]) + 4'(n[col]);
    if (l_ok) sum = sum + 4'(p[cl]) + 4'(c[cl]) + 4'(n[cl]);
    if (r_ok) sum = sum + 4'(p[cr]) + 4'(c[cr]) + 4'(n[cr]);
    return (sum == 4'd3) | (c[col] & (sum == 4'd2));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      cur_q   <= '0;
      next_q  <= '0;
`ifdef LIFE_TORUS_EN
      row0_orig_q <= '0;
`endif
      cnt_q   <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      din_q   <= 1'b0;
      gen_q   <= '0;
      addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            row_q  <= '0;
            prev_q <= '0;
`ifdef LIFE_TORUS_EN
            state_q <= LOAD_TOP;
            addr_q  <= addr_of(LAST_ROW, '0);
`else
            state_q <= LOAD_ROW0;
            addr_q  <= addr_of('0, '0);
`endif
          end
        end
        LOAD_TOP, LOAD_ROW0, FETCH: begin
          // Read data lags the address by one cycle, so cycle k captures column k-1.
          if (cnt_q != '0) begin
            if (state_q == LOAD_TOP) begin
              prev_q[cap_idx] <= mem_dout;
            end else if (state_q == LOAD_ROW0) begin
              cur_q[cap_idx] <= mem_dout;
`ifdef LIFE_TORUS_EN
              row0_orig_q[cap_idx] <= mem_dout;
`endif
            end else begin
              next_q[cap_idx] <= mem_dout;
            end
          end
          if (cnt_q == RD_LAST) begin
            cnt_q <= '0;
            if (state_q == LOAD_TOP) begin
              state_q <= LOAD_ROW0;
              addr_q  <= addr_of('0, '0);
            end else if (state_q == LOAD_ROW0) begin
              state_q <= FETCH;
              addr_q  <= addr_of(row_q + RW'(1), '0);
            end else begin
              state_q <= WRITE;
              we_q    <= 1'b1;
              addr_q  <= addr_of(row_q, '0);
              din_q   <= cell_next(prev_q, cur_q, next_full_d, '0);
            end
          end else begin
            cnt_q <= cnt_q + (CW + 1)'(1);
            if (cnt_q < WR_LAST) addr_q <= addr_q + ADDR_W'(1);
          end
        end
        WRITE: begin
          if (cnt_q == WR_LAST) begin
            prev_q <= cur_q;
            cur_q  <= next_q;
            cnt_q  <= '0;
            if (row_q == LAST_ROW) begin
              state_q <= FINISH;
              we_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              gen_q   <= gen_q + 16'd1;
            end else begin
              row_q <= row_q + RW'(1);
              if (row_q < PEN_ROW) begin
                state_q <= FETCH;
                we_q    <= 1'b0;
                addr_q  <= addr_of(row_q + RW'(2), '0);
              end else begin
                // Last row: its lower neighbour is the saved original row 0 (or dead cells).
                next_q <= last_next_d;
                addr_q <= addr_of(LAST_ROW, '0);
                din_q  <= cell_next(cur_q, next_q, last_next_d, '0);
              end
            end
          end else begin
            cnt_q  <= cnt_q + (CW + 1)'(1);
            addr_q <= addr_q + ADDR_W'(1);
            din_q  <= cell_next(prev_q, cur_q, next_q, col_lo + CW'(1));
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign gen_count = gen_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_din   = din_q;
endmodule

// File: tb/tb_life_step.sv
// Bench for life_step: BRAM model plus a whole-grid B3/S23 reference evaluated per generation.
module tb_life_step;
  localparam int W = 64;
  localparam int H = 64;
  localparam int N = W * H;
`ifdef LIFE_TORUS_EN
  localparam bit TORUS   = 1'b1;
  localparam int EXP_CYC = 8321;
`else
  localparam bit TORUS   = 1'b0;
  localparam int EXP_CYC = 8256;
`endif

  typedef struct packed {
    int ticks;
    int busy_cnt;
    int we_cnt;
    int done_cnt;
    bit post_done;
    bit post_busy;
    bit tmo;
  } run_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, mem_we, mem_din, mem_dout;
  logic [15:0] gen_count;
  logic [11:0] mem_addr;

  always #5 clk = ~clk;

  life_step dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .gen_count(gen_count), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  logic       mem [0:N-1];
  bit         load_req = 1'b0;
  bit [N-1:0] load_img;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) mem[i] <= load_img[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
    mem_dout <= mem[mem_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  int exp_gen = 0;

  function automatic bit [N-1:0] life_ref(input bit [N-1:0] g);
    bit [N-1:0] o;
    int n, rr, cc;
    o = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (TORUS) begin
              rr = (rr + H) % H;
              cc = (cc + W) % W;
            end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
              continue;
            end
            n += int'(g[rr*W+cc]);
          end
        end
        o[r*W+c] = (n == 3) || (g[r*W+c] && n == 2);
      end
    end
    return o;
  endfunction

  function automatic bit [N-1:0] rand_grid();
    bit [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = ($urandom_range(0, 2) == 0);
    return g;
  endfunction

  function automatic int grid_diff(input bit [N-1:0] e);
    int d = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== e[i]) d++;
    return d;
  endfunction

  task automatic load_grid(input bit [N-1:0] img);
    @(negedge clk);
    load_img = img;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic run_gen(input bit hold, output run_t res);
    res = '0;
    start = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!hold) begin
        if (res.ticks == 0) start = 1'b0;
        if (res.ticks == 3000) start = 1'b1;
        if (res.ticks == 3001) start = 1'b0;
      end
      if (busy === 1'b1) res.busy_cnt++;
      if (mem_we === 1'b1) res.we_cnt++;
      if (done === 1'b1) begin
        res.done_cnt++;
        break;
      end
      if (res.ticks >= 20000) begin
        res.tmo = 1'b1;
        break;
      end
      @(posedge clk);
      res.ticks++;
    end
    @(negedge clk);
    res.post_done = done;
    res.post_busy = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, mem_we, mem_din} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, mem_we, mem_din});
    end
    n_vec++;
    if ({gen_count, mem_addr} !== 28'd0) begin
      n_err++;
      $display("FAIL reset_count_addr: got gen=%0d addr=%0d expected 0/0", gen_count, mem_addr);
    end
    rst = 1'b0;
    exp_gen = 0;
    @(negedge clk);
  endtask

  task automatic test_blinker();
    bit [N-1:0] img, expv;
    run_t r;
    int d;
    img = '0;
    img[10*W+10] = 1'b1; img[10*W+11] = 1'b1; img[10*W+12] = 1'b1;
    expv = '0;
    expv[9*W+11] = 1'b1; expv[10*W+11] = 1'b1; expv[11*W+11] = 1'b1;
    load_grid(img);
    run_gen(1'b0, r);
    exp_gen++;
    $display("blinker: ticks=%0d busy=%0d we=%0d done=%0d gen=%0d", r.ticks, r.busy_cnt, r.we_cnt, r.done_cnt, gen_count);
    n_vec++;
    if (r.ticks !== EXP_CYC) begin n_err++; $display("FAIL blinker_latency: got %0d expected %0d", r.ticks, EXP_CYC); end
    n_vec++;
    if (r.busy_cnt !== EXP_CYC) begin n_err++; $display("FAIL blinker_busy_len: got %0d expected %0d", r.busy_cnt, EXP_CYC); end
    n_vec++;
    if (r.we_cnt !== N) begin n_err++; $display("FAIL blinker_we_count: got %0d expected %0d", r.we_cnt, N); end
    n_vec++;
    if ({r.done_cnt, r.post_done, r.post_busy} !== {32'd1, 2'b00}) begin
      n_err++;
      $display("FAIL blinker_done_pulse: got done=%0d post_done=%b post_busy=%b expected 1/0/0", r.done_cnt, r.post_done, r.post_busy);
    end
    n_vec++;
    if (gen_count !== 16'(exp_gen)) begin n_err++; $display("FAIL blinker_gen: got %0d expected %0d", gen_count, exp_gen); end
    d = grid_diff(expv);
    n_vec++;
    if (d != 0) begin n_err++; $display("FAIL blinker_grid: got %0d differing cells expected 0", d); end
  endtask

  task automatic test_back_to_back();
    bit [N-1:0] img;
    run_t r;
    int d;
    img = '0;
    img[20*W+20] = 1'b1; img[20*W+21] = 1'b1; img[21*W+20] = 1'b1; img[21*W+21] = 1'b1;
    load_grid(img);
    for (int k = 0; k < 3; k++) begin
      run_gen(1'b0, r);
      exp_gen++;
      $display("block run %0d: ticks=%0d we=%0d gen=%0d", k, r.ticks, r.we_cnt, gen_count);
      n_vec++;
      if (r.ticks !== EXP_CYC || r.done_cnt !== 1) begin
        n_err++;
        $display("FAIL block_run%0d_latency: got %0d/%0d expected %0d/1", k, r.ticks, r.done_cnt, EXP_CYC);
      end
    end
    n_vec++;
    if (gen_count !== 16'(exp_gen)) begin n_err++; $display("FAIL block_gen: got %0d expected %0d", gen_count, exp_gen); end
    d = grid_diff(img);
    n_vec++;
    if (d != 0) begin n_err++; $display("FAIL block_grid: got %0d differing cells expected 0", d); end
  endtask

  task automatic test_edge_wrap();
    bit [N-1:0] img, expv;
    run_t r;
    int d;
    img = '0;
    img[5*W+63] = 1'b1; img[5*W+0] = 1'b1; img[5*W+1] = 1'b1;
    expv = '0;
    if (TORUS) begin
      expv[4*W] = 1'b1; expv[5*W] = 1'b1; expv[6*W] = 1'b1;
    end
    load_grid(img);
    run_gen(1'b0, r);
    exp_gen++;
    d = grid_diff(expv);
    $display("edge_wrap: ticks=%0d diff=%0d gen=%0d", r.ticks, d, gen_count);
    n_vec++;
    if (d != 0) begin n_err++; $display("FAIL edge_grid: got %0d differing cells expected 0", d); end
    n_vec++;
    if (gen_count !== 16'(exp_gen)) begin n_err++; $display("FAIL edge_gen: got %0d expected %0d", gen_count, exp_gen); end
  endtask

  task automatic test_full_grid();
    bit [N-1:0] img;
    run_t r;
    int d;
    img = '1;
    load_grid(img);
    run_gen(1'b0, r);
    exp_gen++;
    d = grid_diff(life_ref(img));
    $display("full_grid: ticks=%0d we=%0d diff=%0d", r.ticks, r.we_cnt, d);
    n_vec++;
    if (d != 0) begin n_err++; $display("FAIL full_grid: got %0d differing cells expected 0", d); end
    n_vec++;
    if (r.we_cnt !== N) begin n_err++; $display("FAIL full_we_count: got %0d expected %0d", r.we_cnt, N); end
  endtask

  task automatic test_reset_abort();
    bit [N-1:0] img;
    run_t r;
    int ticks, dones, d;
    load_grid(rand_grid());
    start = 1'b1;
    @(posedge clk);
    ticks = 0;
    dones = 0;
    while (ticks < 4000) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dones++;
      @(posedge clk);
      ticks++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("abort: busy=%b we=%b done=%b gen=%0d", busy, mem_we, done, gen_count);
    n_vec++;
    if ({busy, mem_we, done} !== 3'b000) begin n_err++; $display("FAIL abort_flags: got %b expected 000", {busy, mem_we, done}); end
    n_vec++;
    if (gen_count !== 16'd0) begin n_err++; $display("FAIL abort_gen: got %0d expected 0", gen_count); end
    rst = 1'b0;
    exp_gen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_vec++;
    if (dones != 0) begin n_err++; $display("FAIL abort_no_done: got %0d activity cycles expected 0", dones); end
    for (int i = 0; i < N; i++) img[i] = (mem[i] === 1'b1);
    run_gen(1'b0, r);
    exp_gen++;
    d = grid_diff(life_ref(img));
    $display("after_abort: ticks=%0d diff=%0d gen=%0d", r.ticks, d, gen_count);
    n_vec++;
    if (r.ticks !== EXP_CYC || gen_count !== 16'(exp_gen)) begin
      n_err++;
      $display("FAIL after_abort_run: got ticks=%0d gen=%0d expected %0d/%0d", r.ticks, gen_count, EXP_CYC, exp_gen);
    end
    n_vec++;
    if (d != 0) begin n_err++; $display("FAIL after_abort_grid: got %0d differing cells expected 0", d); end
  endtask

  task automatic test_start_held();
    bit [N-1:0] img;
    run_t r1, r2;
    int d, busy_seen;
    img = rand_grid();
    load_grid(img);
    run_gen(1'b1, r1);
    exp_gen++;
    $display("held run 0: ticks=%0d busy=%0d post_busy=%b", r1.ticks, r1.busy_cnt, r1.post_busy);
    n_vec++;
    if (r1.ticks !== EXP_CYC || r1.busy_cnt !== EXP_CYC) begin
      n_err++;
      $display("FAIL held_run0: got ticks=%0d busy=%0d expected %0d", r1.ticks, r1.busy_cnt, EXP_CYC);
    end
    n_vec++;
    if (r1.post_busy !== 1'b0) begin n_err++; $display("FAIL held_idle_gap: got busy=%b expected 0", r1.post_busy); end
    run_gen(1'b1, r2);
    start = 1'b0;
    exp_gen++;
    $display("held run 1: ticks=%0d busy=%0d gen=%0d", r2.ticks, r2.busy_cnt, gen_count);
    n_vec++;
    if (r2.ticks !== EXP_CYC || r2.busy_cnt !== EXP_CYC) begin
      n_err++;
      $display("FAIL held_run1: got ticks=%0d busy=%0d expected %0d", r2.ticks, r2.busy_cnt, EXP_CYC);
    end
    busy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen++;
    end
    n_vec++;
    if (busy_seen != 0 || gen_count !== 16'(exp_gen)) begin
      n_err++;
      $display("FAIL held_release: got busy_cycles=%0d gen=%0d expected 0/%0d", busy_seen, gen_count, exp_gen);
    end
    d = grid_diff(life_ref(life_ref(img)));
    n_vec++;
    if (d != 0) begin n_err++; $display("FAIL held_grid: got %0d differing cells expected 0", d); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_blinker();
    test_back_to_back();
    test_edge_wrap();
    test_full_grid();
    test_reset_abort();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
